booth_pp_accumulator: RTL

Sequential consumer of the five radix-4 Booth partial products (PP0..PP4) that the 8x8 partial-product generator emits for the mantissa multiply. It captures one set of partial products, adds PPi weighted by 4^i over five cycles, and presents the 16-bit product under a valid/ready handshake. It sits between the Booth PP generator and the floating-point normalisation stage.

---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_shift_add.sv | 20 ++
 rtl/booth_pp_accumulator.sv | 98 +++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and sizing for the radix-4 Booth partial-product accumulator.
// Provides the FSM state enum, operand widths and the index width.
package booth_pkg;

    localparam int N_PP  = 5;
    localparam int PP_W  = 16;
    localparam int SHIFT = 2;
    localparam int IDX_W = $clog2(N_PP);
    localparam int SH_W  = $clog2(SHIFT * (N_PP - 1) + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_shift_add.sv
// Combinational step of the accumulator: acc + (pp << SHIFT*idx), modulo 2^PP_W.
// Ports: acc_i (running sum), pp_i (partial product), idx_i (weight index), sum_o.
module booth_shift_add
    import booth_pkg::*;
(
    input  logic [PP_W-1:0]  acc_i,
    input  logic [PP_W-1:0]  pp_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [PP_W-1:0]  sum_o
);

    logic [SH_W-1:0] sh;
    logic [PP_W-1:0] pp_sh;

    // Bits shifted past the top are dropped; the add wraps naturally.
    assign sh    = SH_W'(SHIFT) * SH_W'(idx_i);
    assign pp_sh = pp_i << sh;
    assign sum_o = acc_i + pp_sh;

endmodule

// File: rtl/booth_pp_accumulator.sv
// Captures five Booth partial products, sums PPi*4^i over five cycles and
// offers the 16-bit product P on an out_valid/out_ready handshake.
// Ports: clk, rst_n, in_valid/in_ready, PP0..PP4, out_valid/out_ready, P, busy.
module booth_pp_accumulator
    import booth_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PP_W-1:0] PP0,
    input  logic [PP_W-1:0] PP1,
    input  logic [PP_W-1:0] PP2,
    input  logic [PP_W-1:0] PP3,
    input  logic [PP_W-1:0] PP4,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PP_W-1:0] P,
    output logic            busy
);

    state_t           state_q;
    logic [PP_W-1:0]  acc_q;
    logic [PP_W-1:0]  acc_d;
    logic [IDX_W-1:0] idx_q;
    logic [PP_W-1:0]  pp_q [N_PP];
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    booth_shift_add u_shift_add (
        .acc_i (acc_q),
        .pp_i  (pp_q[idx_q]),
        .idx_i (idx_q),
        .sum_o (acc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < N_PP; i++) begin
                pp_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pp_q[0]    <= PP0;
                        pp_q[1]    <= PP1;
                        pp_q[2]    <= PP2;
                        pp_q[3]    <= PP3;
                        pp_q[4]    <= PP4;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        state_q    <= ACC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ACC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(N_PP - 1)) begin
                        idx_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // in_ready stays low here, so no same-cycle re-accept.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign P         = acc_q;

endmodule
